// File: rtl/clk_ce_gen.sv
// Clock-enable generator: synchronised, qualified PLL lock plus NCH programmable divide-by-N enable strobes.
// Optional phase realignment of all channels via cfg_sync when CLKCE_SYNC_EN is defined.
module clk_ce_gen #(
  parameter int NCH      = 5,
  parameter int DW       = 8,
  parameter int LOCK_CYC = 16,
  parameter int DIV_INIT = 2,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic           pll_locked_in,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  input  logic           cfg_sync,
  output logic [NCH-1:0] ce,
  output logic           locked,
  output logic           rst_out,
  output logic           cfg_ack,
  output logic           cfg_err
);

  localparam int LCW = $clog2(LOCK_CYC + 1);

  logic           s1_q, s1_d, s2_q, s2_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           rst_out_q, rst_out_d;
  logic           cfg_ack_q, cfg_ack_d;
  logic           cfg_err_q, cfg_err_d;
  logic [DW-1:0]  div_q [NCH];
  logic [DW-1:0]  div_d [NCH];
  logic [DW-1:0]  cnt_q [NCH];
  logic [DW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] ce_q, ce_d;
  logic           wr_ok;
  logic           sync_clr;

`ifdef CLKCE_SYNC_EN
  assign sync_clr = cfg_sync;
`else
  logic unused_cfg_sync;
  assign unused_cfg_sync = cfg_sync;
  assign sync_clr        = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    s1_d = pll_locked_in;
    s2_d = s1_q;

    if (!s2_q)
      lock_cnt_d = '0;
    else if (lock_cnt_q == LCW'(LOCK_CYC))
      lock_cnt_d = lock_cnt_q;
    else
      lock_cnt_d = lock_cnt_q + LCW'(1);

    // Gating with s2 makes locked drop one edge after s2 goes low, not two.
    locked_d  = s2_q && (lock_cnt_q == LCW'(LOCK_CYC));
    rst_out_d = ~locked_d;

    wr_ok     = cfg_we && (int'(cfg_ch) < NCH);
    cfg_ack_d = wr_ok;
    cfg_err_d = cfg_we && !wr_ok;

    for (int i = 0; i < NCH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      ce_d[i]  = 1'b0;
      if (wr_ok && (int'(cfg_ch) == i)) begin
        div_d[i] = cfg_div;
        cnt_d[i] = '0;
      end else if (sync_clr || !locked_q || (div_q[i] == '0)) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == div_q[i] - DW'(1)) begin
        cnt_d[i] = '0;
        ce_d[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      rst_out_q  <= 1'b1;
      cfg_ack_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      ce_q       <= '0;
      // NOTE: the divisor/counter arrays are plain flops, so they can and must take the reset value.
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= DW'(DIV_INIT);
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      rst_out_q  <= rst_out_d;
      cfg_ack_q  <= cfg_ack_d;
      cfg_err_q  <= cfg_err_d;
      ce_q       <= ce_d;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ce      = ce_q;
  assign locked  = locked_q;
  assign rst_out = rst_out_q;
  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_ce_gen.sv
// Bench for clk_ce_gen: directed steps then random traffic, checked against a phase-based model.
// Lock is modelled as "PLL seen high on edges t-18..t-2 since the last reset".
module tb_clk_ce_gen;

  localparam int NCH  = 5;
  localparam int MAXE = 4096;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked_in = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_sync = 1'b0;
  logic [4:0] ce;
  logic       locked, rst_out, cfg_ack, cfg_err;

  clk_ce_gen #(.NCH(5), .DW(8), .LOCK_CYC(16), .DIV_INIT(2)) dut (
    .clkin(clkin), .rst(rst), .pll_locked_in(pll_locked_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_sync(cfg_sync),
    .ce(ce), .locked(locked), .rst_out(rst_out), .cfg_ack(cfg_ack), .cfg_err(cfg_err)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int failures = 0;
  int t = -1;
  int last_rst = 0;
  bit good [MAXE];
  bit m_locked = 1'b0;
  bit m_ack = 1'b0;
  bit m_err = 1'b0;
  bit [4:0] m_ce = '0;
  int m_div [NCH];
  int m_anchor [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // One clock edge: apply inputs, advance the model, compare all outputs #1 later.
  task automatic step(input bit r, input bit pll, input bit we, input logic [2:0] ch,
                      input logic [7:0] dv, input bit sy);
    bit lp;
    bit sync_eff;
    rst = r; pll_locked_in = pll; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_sync = sy;
    @(posedge clkin);
    t++;
    lp = m_locked;
`ifdef CLKCE_SYNC_EN
    sync_eff = sy;
`else
    sync_eff = 1'b0;
`endif
    good[t] = pll && !r;
    if (r) last_rst = t;
    m_locked = !r && (t - 18 > last_rst);
    if (m_locked)
      for (int k = t - 18; k <= t - 2; k++) if (!good[k]) m_locked = 1'b0;
    m_ack = !r && we && (ch < 3'(NCH));
    m_err = !r && we && (ch >= 3'(NCH));
    for (int i = 0; i < NCH; i++) begin
      m_ce[i] = 1'b0;
      if (r) begin
        m_div[i] = 2; m_anchor[i] = t;
      end else if (we && (int'(ch) == i)) begin
        m_div[i] = int'(dv); m_anchor[i] = t;
      end else if (sync_eff || !lp || m_div[i] == 0) begin
        m_anchor[i] = t;
      end else begin
        m_ce[i] = ((t - m_anchor[i]) % m_div[i]) == 0;
      end
    end
    #1;
    check("ce", 32'(ce), 32'(m_ce));
    check("locked", 32'(locked), 32'(m_locked));
    check("rst_out", 32'(rst_out), 32'(!m_locked));
    check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  initial begin
    int t0, w, s;
    bit got;

    // Reset with stray activity on every input.
    step(1'b1, 1'b1, 1'b1, 3'd1, 8'd7, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    check("rst_out_in_reset", 32'(rst_out), 32'd1);
    check("ce_in_reset", 32'(ce), 32'd0);

    // Lock latency: first sampling edge to locked.
    t0 = t + 1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      idle(1);
      if (locked === 1'b1) got = 1'b1;
    end
    check("lock_seen", 32'(got), 32'd1);
    check("lock_latency", 32'(t - t0), 32'd18);
    idle(10);

    // Write ch2 div=4 while locked.
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'd4, 1'b0);
    w = t;
    check("wr_ack", 32'(cfg_ack), 32'd1);
    idle(3);
    check("ch2_before_w4", 32'(ce[2]), 32'd0);
    idle(1);
    check("ch2_at_w4", 32'(ce[2]), 32'd1);
    check("ch2_at_w4_edge", 32'(t - w), 32'd4);
    idle(4);
    check("ch2_at_w8", 32'(ce[2]), 32'd1);
    idle(5);

    // One-cycle PLL dropout.
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    idle(1);
    check("still_locked_2nd_edge", 32'(locked), 32'd1);
    idle(1);
    check("unlocked_3rd_edge", 32'(locked), 32'd0);
    idle(1);
    check("ce_forced_off", 32'(ce), 32'd0);
    idle(24);

    // Out-of-range channel.
    step(1'b0, 1'b1, 1'b1, 3'd6, 8'd9, 1'b0);
    check("bad_err", 32'(cfg_err), 32'd1);
    check("bad_no_ack", 32'(cfg_ack), 32'd0);
    step(1'b0, 1'b1, 1'b1, 3'd7, 8'd3, 1'b0);
    idle(12);

    // Disabled channel and divide-by-one.
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd1, 8'd1, 1'b0);
    idle(1);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("ch0_off", 32'(ce[0]), 32'd0);
      check("ch1_on", 32'(ce[1]), 32'd1);
    end

    // Realignment of ch3 (div 3) and ch4 (div 5).
    step(1'b0, 1'b1, 1'b1, 3'd3, 8'd3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd4, 8'd5, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
    s = t;
    idle(2);
`ifdef CLKCE_SYNC_EN
    check("ch3_before_s3", 32'(ce[3]), 32'd0);
`endif
    idle(1);
`ifdef CLKCE_SYNC_EN
    check("ch3_at_s3", 32'(ce[3]), 32'd1);
`endif
    idle(2);
`ifdef CLKCE_SYNC_EN
    check("ch4_at_s5", 32'(ce[4]), 32'd1);
    check("ch4_at_s5_edge", 32'(t - s), 32'd5);
`endif
    // Write coinciding with sync still loads and acknowledges.
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'd3, 1'b1);
    check("sync_wr_ack", 32'(cfg_ack), 32'd1);
    idle(15);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 249) == 0, $urandom_range(0, 99) != 0,
           $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 6)), $urandom_range(0, 15) == 0);
    end

    // Reset mid-count overriding a write and a sync.
    idle(25);
    step(1'b1, 1'b1, 1'b1, 3'd2, 8'd7, 1'b1);
    check("rst_wins_ack", 32'(cfg_ack), 32'd0);
    check("rst_wins_locked", 32'(locked), 32'd0);
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_ce_gen.md
CLK_CE_GEN -- requirements
Module: clk_ce_gen

Interface
REQ-001 Parameters SHALL be:
- NCH, default 5, number of clock-enable channels (1..8).
- DW, default 8, divisor width.
- LOCK_CYC, default 16, number of consecutive synchronised lock cycles required (>=1).
- DIV_INIT, default 2, divisor loaded into every channel at reset.
REQ-002 Ports SHALL be, with CHW = max(1, ceil(log2(NCH))):
- clkin  in  1  sole clock; all flops rising-edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked_in  in  1  asynchronous lock from the PLL.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CHW  target channel.
- cfg_div  in  DW  new divisor.
- cfg_sync  in  1  realign all channels (see Configuration).
- ce  out  NCH  per-channel one-cycle enable strobes.
- locked  out  1  qualified lock.
- rst_out  out  1  downstream reset, high while not locked.
- cfg_ack  out  1  one-cycle pulse after an accepted write.
- cfg_err  out  1  one-cycle pulse after a rejected write.

Function
REQ-003 pll_locked_in SHALL pass through a 2-flop synchroniser (s1, s2) before any use.
REQ-004 Lock counter SHALL increment each cycle s2=1, saturate at LOCK_CYC, and clear on any cycle s2=0.
REQ-005 locked SHALL be registered; it rises in the cycle after the counter reaches LOCK_CYC and falls in the cycle after s2 samples 0.
REQ-006 rst_out SHALL be a registered copy of ~locked.
REQ-007 Each channel SHALL hold a DW-bit divisor register div[i] and a DW-bit counter cnt[i].
REQ-008 While locked=0, every cnt SHALL be held at 0 and every ce bit SHALL be held at 0.
REQ-009 While locked=1 and div[i]>=1, each edge SHALL apply: if cnt[i]==div[i]-1 then cnt[i]<=0 and ce[i]<=1, else cnt[i]<=cnt[i]+1 and ce[i]<=0.
REQ-010 Consequently ce[i] SHALL first be high div[i] cycles after the first locked=1 cycle, then exactly once every div[i] cycles; div[i]=1 SHALL give ce[i] constantly high.
REQ-011 div[i]=0 SHALL disable channel i: cnt[i] is held at 0 and ce[i] stays 0.
REQ-012 A write (cfg_we=1, cfg_ch<NCH) SHALL:
- load div[cfg_ch]<=cfg_div;
- clear cnt[cfg_ch] and ce[cfg_ch];
- pulse cfg_ack for 1 cycle.
The next ce pulse for that channel follows REQ-010, counted from the cycle after the write.
REQ-013 A write with cfg_ch>=NCH SHALL change no state and SHALL pulse cfg_err for 1 cycle.
REQ-014 When a write and a counter wrap coincide on the same channel, the write SHALL take precedence.
REQ-015 Writes SHALL be accepted regardless of the state of locked.
REQ-016 Other channels SHALL be unaffected by a write.

Reset
REQ-017 When rst=1 at an edge, the following SHALL be set:
- s1, s2, lock counter = 0;
- locked = 0, rst_out = 1;
- all cnt = 0, ce = 0;
- all div = DIV_INIT;
- cfg_ack = 0, cfg_err = 0.
REQ-018 Reset SHALL override every concurrent write, sync or lock event, including mid-count.

Configuration
REQ-019 Macro CLKCE_SYNC_EN SHALL control the sync feature.
- Defined: cfg_sync=1 at an edge clears every cnt and ce, so all channels restart phase-aligned. If a write coincides with the sync, the new divisor is still loaded and cfg_ack still pulses.
- Undefined: the cfg_sync port is present but ignored, with no logic generated for it.

Verification (NCH=5, DW=8, LOCK_CYC=16, DIV_INIT=2)
REQ-020 Reset, then hold pll_locked_in=1: locked and ~rst_out rise exactly 18 cycles after the first edge that samples pll_locked_in high; ce[0..4] then pulse every 2 cycles in phase.
REQ-021 While locked, write ch2 div=4: cfg_ack pulses 1 cycle; ce[2] pulses in cycles W+4, W+8, ..., where W is the write cycle; ce[0,1,3,4] keep their unchanged 2-cycle cadence.
REQ-022 While locked, drive pll_locked_in low for 1 cycle: locked falls 3 edges later, ce is forced to 0 and rst_out=1; relock takes a full 18 cycles.
REQ-023 Write cfg_ch=6, div=9: cfg_err pulses 1 cycle, cfg_ack stays 0, and every div value is unchanged.
REQ-024 Write ch0 div=0 and ch1 div=1: ce[0] stays 0 and ce[1] stays constantly 1 while locked.
REQ-025 With CLKCE_SYNC_EN, set ch3 div=3 and ch4 div=5, then pulse cfg_sync: both channels' next ce fall 3 and 5 cycles after the sync. Without the macro, the same cfg_sync pulse leaves the cadence undisturbed.
